// File: rtl/legv8_ctrl_pkg.sv
// LEGv8 multicycle control: opcode match/mask constants, state and class enums.
// Shared by ctrl_decoder and multicycle_control_unit (CTRL_CBNZ_EN adds CBNZ).
package legv8_ctrl_pkg;

  localparam int OPC_W = 11;

  localparam logic [OPC_W-1:0] LDUR_MASK  = 11'b11111111111;
  localparam logic [OPC_W-1:0] LDUR_MATCH = 11'b11111000010;
  localparam logic [OPC_W-1:0] STUR_MASK  = 11'b11111111111;
  localparam logic [OPC_W-1:0] STUR_MATCH = 11'b11111000000;
  localparam logic [OPC_W-1:0] CBZ_MASK   = 11'b11111111000;
  localparam logic [OPC_W-1:0] CBZ_MATCH  = 11'b10110100000;
  localparam logic [OPC_W-1:0] CBNZ_MASK  = 11'b11111111000;
  localparam logic [OPC_W-1:0] CBNZ_MATCH = 11'b10110101000;
  localparam logic [OPC_W-1:0] B_MASK     = 11'b11111100000;
  localparam logic [OPC_W-1:0] B_MATCH    = 11'b00010100000;
  localparam logic [OPC_W-1:0] RTYPE_MASK = 11'b10011110111;
  localparam logic [OPC_W-1:0] RTYPE_MATCH= 11'b10001010000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASSB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_e;

  typedef enum logic [2:0] {
    C_NOP,
    C_LDUR,
    C_STUR,
    C_CBZ,
    C_CBNZ,
    C_B,
    C_RTYPE
  } class_e;

  function automatic logic op_hit(
    input logic [OPC_W-1:0] op,
    input logic [OPC_W-1:0] mask,
    input logic [OPC_W-1:0] match
  );
    return (op & mask) == match;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational opcode -> instruction class for the multicycle sequencer.
// CBNZ is recognised only when CTRL_CBNZ_EN is defined.
module ctrl_decoder
  import legv8_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output class_e           cls
);

  // Match patterns are disjoint, so at most one arm can fire.
  always_comb begin
    cls = C_NOP;
    unique case (1'b1)
      op_hit(opcode, LDUR_MASK, LDUR_MATCH):   cls = C_LDUR;
      op_hit(opcode, STUR_MASK, STUR_MATCH):   cls = C_STUR;
      op_hit(opcode, CBZ_MASK, CBZ_MATCH):     cls = C_CBZ;
`ifdef CTRL_CBNZ_EN
      op_hit(opcode, CBNZ_MASK, CBNZ_MATCH):   cls = C_CBNZ;
`endif
      op_hit(opcode, B_MASK, B_MATCH):         cls = C_B;
      op_hit(opcode, RTYPE_MASK, RTYPE_MATCH): cls = C_RTYPE;
      default:                                 cls = C_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle LEGv8 control sequencer with memory timeout and retire counter.
// Define CTRL_CBNZ_EN to add the CBNZ class and the branch_nz output.
module multicycle_control_unit
  import legv8_ctrl_pkg::*;
#(
  parameter int OPCODE_W       = 11,
  parameter int ALUOP_W        = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg2loc,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic                unc_branch,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                fault,
`ifdef CTRL_CBNZ_EN
  output logic                branch_nz,
`endif
  output logic [CNT_W-1:0]    instr_count
);

  localparam int WAIT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  state_e            state_q, state_d;
  class_e            cls_q, cls_d, dec_cls;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wait_step;
  logic              retire;

  ctrl_decoder u_dec (
    .opcode (opcode),
    .cls    (dec_cls)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    wait_step = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (run) begin
          if (imem_ready) state_d = S_DECODE;
          else            wait_step = 1'b1;
        end
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        state_d = (dec_cls == C_NOP) ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_LDUR, C_STUR: state_d = S_MEM;
          C_RTYPE:        state_d = S_WB;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_ready)
          state_d = (cls_q == C_LDUR) ? S_WB : S_FETCH;
        else
          wait_step = 1'b1;
      end
      S_WB:    state_d = S_FETCH;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
    // The threshold cycle only faults when ready is still low.
    if (TO_EN && wait_step && (wait_q == WAIT_LAST))
      state_d = S_FAULT;
  end

  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= C_NOP;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (TO_EN && wait_step)
        wait_q <= wait_q + 1'b1;
      if (retire)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign instr_count = cnt_q;

  // Strobes are forced low while reset is held.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    unc_branch = 1'b0;
    alu_op     = ALUOP_W'(ALU_ADD);
    fault      = 1'b0;
`ifdef CTRL_CBNZ_EN
    branch_nz  = 1'b0;
`endif
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          imem_req = run;
          ir_write = run & imem_ready;
          pc_write = run & imem_ready;
        end
        S_EXEC: begin
          case (cls_q)
            C_LDUR: alu_src = 1'b1;
            C_STUR: begin
              alu_src = 1'b1;
              reg2loc = 1'b1;
            end
            C_RTYPE: alu_op = ALUOP_W'(ALU_FUNCT);
            C_CBZ: begin
              reg2loc = 1'b1;
              alu_op  = ALUOP_W'(ALU_PASSB);
              branch  = 1'b1;
            end
`ifdef CTRL_CBNZ_EN
            C_CBNZ: begin
              reg2loc   = 1'b1;
              alu_op    = ALUOP_W'(ALU_PASSB);
              branch    = 1'b1;
              branch_nz = 1'b1;
            end
`endif
            C_B: begin
              alu_op     = ALUOP_W'(ALU_PASSB);
              unc_branch = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_req  = 1'b1;
          alu_src   = 1'b1;
          reg2loc   = (cls_q == C_STUR);
          mem_read  = (cls_q == C_LDUR);
          mem_write = (cls_q == C_STUR);
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == C_LDUR);
        end
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit (TIMEOUT_CYCLES=4).
// Driver queues expected strobe vectors; a negedge monitor pops and compares.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_ready, dmem_ready;
  logic [10:0] opcode;
  logic        imem_req, dmem_req, ir_write, pc_write;
  logic        reg2loc, alu_src, mem_to_reg, reg_write;
  logic        mem_read, mem_write, branch, unc_branch;
  logic [1:0]  alu_op;
  logic        fault;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .OPCODE_W       (11),
    .ALUOP_W        (2),
    .TIMEOUT_CYCLES (4),
    .CNT_W          (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .opcode      (opcode),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg2loc     (reg2loc),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .branch      (branch),
    .unc_branch  (unc_branch),
    .alu_op      (alu_op),
    .fault       (fault),
    .instr_count (instr_count)
  );

  localparam logic [14:0] IREQ  = 15'h4000;
  localparam logic [14:0] DREQ  = 15'h2000;
  localparam logic [14:0] IRW   = 15'h1000;
  localparam logic [14:0] PCW   = 15'h0800;
  localparam logic [14:0] R2L   = 15'h0400;
  localparam logic [14:0] ASRC  = 15'h0200;
  localparam logic [14:0] M2R   = 15'h0100;
  localparam logic [14:0] RW    = 15'h0080;
  localparam logic [14:0] MR    = 15'h0040;
  localparam logic [14:0] MW    = 15'h0020;
  localparam logic [14:0] BR    = 15'h0010;
  localparam logic [14:0] UB    = 15'h0008;
  localparam logic [14:0] APASS = 15'h0002;
  localparam logic [14:0] AFN   = 15'h0004;
  localparam logic [14:0] FLT   = 15'h0001;

  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_RTYPE = 11'b10001011000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100101;
  localparam logic [10:0] OP_B     = 11'b00010100000;
  localparam logic [10:0] OP_CBNZ  = 11'b10110101000;

  localparam logic [14:0] LD_EX = ASRC;
  localparam logic [14:0] LD_MM = DREQ | MR | ASRC;
  localparam logic [14:0] LD_WB = RW | M2R;
  localparam logic [14:0] ST_EX = ASRC | R2L;
  localparam logic [14:0] ST_MM = DREQ | MW | ASRC | R2L;

  typedef struct {
    logic [14:0] v;
    logic [31:0] c;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        chk = 1'b0;
  logic [31:0] ec = 32'd0;
  logic [14:0] vec;

  assign vec = {imem_req, dmem_req, ir_write, pc_write, reg2loc,
                alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                branch, unc_branch, alu_op, fault};

  always @(negedge clk) begin : monitor
    exp_t e;
    if (vec != 15'd0 || chk) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_cycle: got vec=%h count=%0d, required idle",
                 vec, instr_count);
      end else begin
        e = q.pop_front();
        if (vec !== e.v || instr_count !== e.c) begin
          n_bad++;
          $display("FAIL ctrl_vec @%0t: got vec=%h count=%0d, required vec=%h count=%0d",
                   $time, vec, instr_count, e.v, e.c);
        end
      end
    end
  end

  task automatic cyc(input logic [14:0] e, input bit f);
    if (e != 15'd0 || f) q.push_back('{v: e, c: ec});
    chk = f;
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic fetch(input logic [10:0] op, input int iw);
    run = 1'b1;
    opcode = op;
    imem_ready = 1'b0;
    repeat (iw) cyc(IREQ, 1'b0);
    imem_ready = 1'b1;
    cyc(IREQ | IRW | PCW, 1'b0);
    imem_ready = 1'b0;
  endtask

  task automatic instr(input logic [10:0] op, input int iw,
                       input logic [14:0] ex, input logic [14:0] mv,
                       input int dw, input logic [14:0] wb);
    fetch(op, iw);
    cyc(15'd0, 1'b0);
    if (ex != 15'd0) begin
      cyc(ex, 1'b0);
      if (mv != 15'd0) begin
        dmem_ready = 1'b0;
        repeat (dw) cyc(mv, 1'b0);
        dmem_ready = 1'b1;
        cyc(mv, 1'b0);
        dmem_ready = 1'b0;
      end
      if (wb != 15'd0) cyc(wb, 1'b0);
    end
    ec = ec + 1;
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    opcode = 11'd0;
    @(posedge clk);
    #1;
    cyc(15'd0, 1'b1);
    rst_n = 1'b1;

    instr(OP_LDUR, 2, LD_EX, LD_MM, 2, LD_WB);
    instr(OP_STUR, 0, ST_EX, ST_MM, 3, 15'd0);
    instr(OP_RTYPE, 1, AFN, 15'd0, 0, RW);
    instr(OP_CBZ, 0, R2L | BR | APASS, 15'd0, 0, 15'd0);
    instr(OP_B, 0, UB | APASS, 15'd0, 0, 15'd0);
    instr(11'd0, 0, 15'd0, 15'd0, 0, 15'd0);
    instr(OP_CBNZ, 0, 15'd0, 15'd0, 0, 15'd0);
    instr(OP_LDUR, 3, LD_EX, LD_MM, 3, LD_WB);

    run = 1'b0;
    repeat (8) cyc(15'd0, 1'b1);

    fetch(OP_STUR, 3);
    cyc(15'd0, 1'b0);
    cyc(ST_EX, 1'b0);
    dmem_ready = 1'b0;
    repeat (4) cyc(ST_MM, 1'b0);
    repeat (3) cyc(FLT, 1'b0);
    rst_n = 1'b0;
    cyc(15'd0, 1'b1);
    ec = 32'd0;
    cyc(15'd0, 1'b1);
    rst_n = 1'b1;

    fetch(OP_STUR, 0);
    cyc(15'd0, 1'b0);
    cyc(ST_EX, 1'b0);
    cyc(ST_MM, 1'b0);
    rst_n = 1'b0;
    cyc(15'd0, 1'b1);
    rst_n = 1'b1;
    cyc(IREQ, 1'b0);
    instr(OP_RTYPE, 0, AFN, 15'd0, 0, RW);

    run = 1'b0;
    repeat (3) cyc(15'd0, 1'b1);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
